// File: rtl/commit_pkg.sv
// Shared types and helpers for the retire-to-checker serialization path.
package commit_pkg;

  localparam int unsigned MAX_XLEN      = 64;
  localparam int unsigned DEFAULT_DEPTH = 8;

  // Pointer width carries one extra wrap bit so full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned PTR_W = ptr_width(DEFAULT_DEPTH);

  // Low bit index of lane `lane` inside a lane-packed bus of `width`-bit fields.
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

  typedef struct packed {
    logic [MAX_XLEN-1:0] pc;
    logic [31:0]         insn;
    logic                wen;
    logic [4:0]          waddr;
    logic [MAX_XLEN-1:0] wdata;
  } commit_entry_t;

endpackage

// File: rtl/commit_compactor.sv
// Lane compaction: prefix popcount gives each valid lane its slot offset.
module commit_compactor #(
  parameter  int unsigned COMMITS = 2,
  localparam int unsigned CW      = $clog2(COMMITS + 1)
) (
  input  logic [COMMITS-1:0]         valid,
  output logic [COMMITS-1:0][CW-1:0] offset,
  output logic [CW-1:0]              push_cnt
);

  logic [CW-1:0] acc;

  // Running count of valid lanes below each lane; the total is the push count.
  always_comb begin
    acc    = '0;
    offset = '0;
    for (int unsigned i = 0; i < COMMITS; i++) begin
      offset[i] = acc;
      acc       = acc + CW'(valid[i]);
    end
    push_cnt = acc;
  end

endmodule

// File: rtl/commit_serializer.sv
// Multi-lane retire FIFO draining one commit per cycle to the checker.
module commit_serializer
  import commit_pkg::*;
#(
  parameter int unsigned COMMITS = 2,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned XLEN    = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [COMMITS-1:0]      in_valid,
  input  logic [COMMITS*XLEN-1:0] in_pc,
  input  logic [COMMITS*32-1:0]   in_insn,
  input  logic [COMMITS-1:0]      in_wen,
  input  logic [COMMITS*5-1:0]    in_waddr,
  input  logic [COMMITS*XLEN-1:0] in_wdata,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [31:0]             out_insn,
  output logic                    out_wen,
  output logic [4:0]              out_waddr,
  output logic [XLEN-1:0]         out_wdata,
  output logic [63:0]             retired,
  output logic                    overflow
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned AW = PW - 1;
  localparam int unsigned CW = $clog2(COMMITS + 1);

  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [PW-1:0]              count;
  logic                       run;
  logic                       pop;
  logic [COMMITS-1:0][CW-1:0] offset;
  logic [CW-1:0]              push_cnt;
  logic [AW-1:0]              slot [COMMITS];
  commit_entry_t              lane_entry [COMMITS];
  commit_entry_t              mem [DEPTH];
  commit_entry_t              head;

  commit_compactor #(.COMMITS(COMMITS)) u_compactor (
    .valid    (in_valid),
    .offset   (offset),
    .push_cnt (push_cnt)
  );

  // in_ready looks only at registered count; run keeps it low until the first edge after reset.
  assign count     = wr_ptr - rd_ptr;
  assign in_ready  = run && (count <= PW'(DEPTH - COMMITS));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_pc    = head.pc[XLEN-1:0];
  assign out_insn  = head.insn;
  assign out_wen   = head.wen;
  assign out_waddr = head.waddr;
  assign out_wdata = head.wdata[XLEN-1:0];

  // Unpack lane fields and compute each lane's destination slot.
  always_comb begin
    for (int unsigned i = 0; i < COMMITS; i++) begin
      lane_entry[i].pc    = MAX_XLEN'(in_pc[lane_lo(i, XLEN) +: XLEN]);
      lane_entry[i].insn  = in_insn[lane_lo(i, 32) +: 32];
      lane_entry[i].wen   = in_wen[i];
      lane_entry[i].waddr = in_waddr[lane_lo(i, 5) +: 5];
      lane_entry[i].wdata = MAX_XLEN'(in_wdata[lane_lo(i, XLEN) +: XLEN]);
      slot[i]             = wr_ptr[AW-1:0] + AW'(offset[i]);
    end
  end

  // Storage write: valid lanes land in consecutive slots from wr_ptr; contents are never reset.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < COMMITS; i++) begin
      if (in_ready && in_valid[i]) begin
        mem[slot[i]] <= lane_entry[i];
      end
    end
  end

  // Pointers, statistics and sticky overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      retired  <= '0;
      overflow <= 1'b0;
      run      <= 1'b0;
    end else begin
      run <= 1'b1;
      if (in_ready) begin
        wr_ptr <= wr_ptr + PW'(push_cnt);
      end else if (|in_valid) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        retired <= retired + 64'd1;
      end
    end
  end

endmodule
